imem_boot_loader: RTL
=====================

Name: imem_boot_loader

Overview:
- Upstream boot stage for the single-cycle RISC-V core.
- Accepts a byte stream carrying a program image and assembles little-endian 32-bit words.
- Writes each word into instruction memory, then releases the core's active-low reset once the whole image has been loaded and checksum-verified.
- Holds the core in reset until the load succeeds; on any error the core stays in reset permanently.

Parameters:
ADDR_WIDTH, 10, instruction-memory word-address width; capacity 2^ADDR_WIDTH words

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset
in_valid  input  1  input byte valid
in_data  input  8  input byte
in_ready  output  1  loader can accept a byte this cycle
imem_we  output  1  instruction-memory write strobe, one cycle per word
imem_addr  output  ADDR_WIDTH  word address of the write
imem_wdata  output  32  word being written
core_rst  output  1  active-low reset to the processor core; 0 = core held in reset
load_done  output  1  image loaded and verified (sticky)
load_err  output  1  load failed (sticky)
words_loaded  output  ADDR_WIDTH+1  count of words written so far

Behaviour:
- Reset (rst=0, asynchronous):
  - Outputs: in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, core_rst=0, load_done=0, load_err=0, words_loaded=0.
  - Internal state: FSM goes to HDR_LO; checksum accumulator cleared; byte counter cleared.
  - The first cycle after rst deasserts may already present in_ready=1.
- Handshake: a byte is accepted on a rising edge where in_valid & in_ready. Gaps in in_valid are allowed anywhere; no timeout.
- in_ready=1 in states HDR_LO, HDR_HI, DATA, CSUM. in_ready=0 in DONE and ERROR.
- Image format: N_lo, N_hi (16-bit word count N), then 4*N data bytes (LSB first per word), then 1 checksum byte.
- Checksum: XOR of every byte preceding it, header included.
- FSM:
  - HDR_LO: accept byte, latch N[7:0] -> HDR_HI.
  - HDR_HI: accept byte, latch N[15:8].
    - If N > 2^ADDR_WIDTH -> ERROR.
    - Else if N == 0 -> CSUM.
    - Else -> DATA.
  - DATA: accept bytes into a 2-bit byte lane counter.
    - On the 4th byte of word k, the next cycle drives imem_we=1, imem_addr=k, imem_wdata={b3,b2,b1,b0}, and words_loaded increments to k+1 in that same cycle.
    - After word N-1's 4th byte -> CSUM.
    - The byte following a 4th byte may be accepted in the same cycle as the write (no stall).
  - CSUM: accept byte.
    - If it equals the accumulator -> DONE.
    - Else -> ERROR.
  - DONE: load_done=1, core_rst=1 from the first cycle after the checksum byte is accepted; stays there until rst.
  - ERROR: load_err=1 from the cycle after the failing byte; core_rst stays 0; stays there until rst.
- imem_we is asserted only for completed words; never in DONE/ERROR except the pending write of the final word.
- Address wrap: impossible, because N ≤ 2^ADDR_WIDTH is enforced and the last address is 2^ADDR_WIDTH-1.
- Reset mid-load:
  - All progress is discarded; words already written stay in memory but are not trusted.
  - A fresh header is required; core_rst drops to 0 asynchronously.
- Bytes presented in DONE/ERROR are not accepted and are not consumed.

Test Plan:
- Normal load, ADDR_WIDTH=10. Bytes 02 00 13 05 10 00 93 05 20 00 B2, back-to-back.
  - Write addr 0 = 0x00100513, addr 1 = 0x00200593, words_loaded=2.
  - Then load_done=1, core_rst=1, in_ready=0.
- Same image with random in_valid gaps (0-5 idle cycles).
  - Identical writes and final state; imem_we pulses exactly twice.
- Empty image: 00 00 00.
  - No imem_we; load_done=1 and core_rst=1 the cycle after the 3rd byte.
- Bad checksum: the normal image with last byte B3.
  - Both words written; load_err=1; core_rst stays 0; load_done=0.
- Oversize header: 01 04 (N=1025).
  - load_err=1 the cycle after the 2nd byte; no imem_we; in_ready=0 afterwards.
- Reset mid-load: assert rst=0 after 6 bytes of the normal image, release, resend the full image.
  - Outputs return to reset values immediately; the second load completes as in scenario 1.

Source files
------------

// File: rtl/imem_boot_loader_if.sv
// Byte-stream input handshake and instruction-memory write bus for the boot loader.
// The master drives the byte stream; the slave (the loader) drives the memory write port.
interface imem_boot_loader_if #(
  parameter int ADDR_WIDTH = 10
);
  logic                  in_valid;
  logic [7:0]            in_data;
  logic                  in_ready;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_wdata;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  imem_we,
    input  imem_addr,
    input  imem_wdata
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output imem_we,
    output imem_addr,
    output imem_wdata
  );
endinterface

// File: rtl/imem_boot_loader.sv
// Boot loader: parses a length-prefixed, XOR-checksummed byte image into 32-bit
// instruction-memory writes and releases the core reset only after a verified load.
module imem_boot_loader #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  imem_boot_loader_if.slave     bus,
  output logic                  core_rst,
  output logic                  load_done,
  output logic                  load_err,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  typedef enum logic [2:0] {
    HDR_LO,
    HDR_HI,
    DATA,
    CSUM,
    DONE,
    ERROR
  } state_t;

  // Wide enough that the capacity compare works for any realistic ADDR_WIDTH.
  localparam logic [32:0] CAPACITY = 33'(1) << ADDR_WIDTH;

  state_t                state_q;
  state_t                state_d;
  logic [7:0]            n_lo_q;
  logic [15:0]           n_words_q;
  logic [1:0]            lane_q;
  logic [23:0]           buf_q;
  logic [7:0]            csum_q;
  logic                  ready_q;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [ADDR_WIDTH:0]   count_q;

  logic                  accept;
  logic                  word_complete;
  logic                  last_word;
  logic                  oversize;
  logic [15:0]           n_hdr;

  assign accept        = bus.in_valid & ready_q;
  assign word_complete = accept && (state_q == DATA) && (lane_q == 2'd3);
  assign n_hdr         = {bus.in_data, n_lo_q};
  assign oversize      = {17'd0, n_hdr} > CAPACITY;
  assign last_word     = (33'(count_q) + 33'd1) == 33'(n_words_q);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      HDR_LO: begin
        if (accept) begin
          state_d = HDR_HI;
        end
      end
      HDR_HI: begin
        if (accept) begin
          if (oversize) begin
            state_d = ERROR;
          end else if (n_hdr == 16'd0) begin
            state_d = CSUM;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (word_complete && last_word) begin
          state_d = CSUM;
        end
      end
      CSUM: begin
        if (accept) begin
          state_d = (bus.in_data == csum_q) ? DONE : ERROR;
        end
      end
      DONE: begin
        state_d = DONE;
      end
      ERROR: begin
        state_d = ERROR;
      end
      default: begin
        state_d = ERROR;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= HDR_LO;
    end else begin
      state_q <= state_d;
    end
  end

  // Ready is registered from the next state so it is low throughout reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_q   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      count_q   <= '0;
      n_lo_q    <= '0;
      n_words_q <= '0;
      lane_q    <= '0;
      buf_q     <= '0;
      csum_q    <= '0;
    end else begin
      ready_q <= (state_d != DONE) && (state_d != ERROR);
      we_q    <= word_complete;
      if (accept && ((state_q == HDR_LO) || (state_q == HDR_HI) || (state_q == DATA))) begin
        csum_q <= csum_q ^ bus.in_data;
      end
      if (accept && (state_q == HDR_LO)) begin
        n_lo_q <= bus.in_data;
      end
      if (accept && (state_q == HDR_HI)) begin
        n_words_q <= n_hdr;
      end
      if (accept && (state_q == DATA)) begin
        lane_q <= lane_q + 2'd1;
        unique case (lane_q)
          2'd0: buf_q[7:0]   <= bus.in_data;
          2'd1: buf_q[15:8]  <= bus.in_data;
          2'd2: buf_q[23:16] <= bus.in_data;
          2'd3: begin
            addr_q  <= count_q[ADDR_WIDTH-1:0];
            wdata_q <= {bus.in_data, buf_q};
            count_q <= count_q + 1'b1;
          end
          default: begin
            buf_q <= buf_q;
          end
        endcase
      end
    end
  end

  assign bus.in_ready   = ready_q;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign words_loaded   = count_q;
  assign load_done      = (state_q == DONE);
  assign load_err       = (state_q == ERROR);
  assign core_rst       = (state_q == DONE);

endmodule
